alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Execute-issue stage directly upstream of the 8-bit combinational ALU.
- Accepts decoded instructions via valid/ready and reads the 8-entry register file.
- Holds operands in an issue register that drives the ALU. Writes the ALU result back into the register file on commit.
- Owns the shift-carry and parity flag registers and bypasses in-flight results to the next instruction.

Parameters:
A, 3, ALU command width minus 1 (command is A+1 bits)
DW, 8, data path width
RW, 3, register index width (2**RW registers)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  global hold; freezes issue register, blocks commit and accept
dec_valid_i  in  1  decoder has an instruction
dec_ready_o  out  1  stage accepts this cycle
dec_cmd_i  in  A+1  ALU command
dec_ra_i  in  RW  source register A
dec_rb_i  in  RW  source register B
dec_rd_i  in  RW  destination register
dec_we_i  in  1  write result to rd
dec_imm_sel_i  in  1  1: operand A = dec_imm_i instead of R[ra]
dec_imm_i  in  DW  immediate
alu_cmd_o  out  A+1  registered command to ALU
alu_ina_o  out  DW  registered operand A
alu_inb_o  out  DW  registered operand B
alu_sc_o  out  1  carry flag to ALU sc_i
alu_rslt_i  in  DW  ALU result
alu_sc_i  in  1  ALU shift-carry out
alu_pari_i  in  1  ALU parity out
commit_o  out  1  issue register retired this cycle
flag_pari_o  out  1  parity flag register
dbg_addr_i  in  RW  debug register read index
dbg_data_o  out  DW  combinational R[dbg_addr_i]

Behaviour:
- Reset (rst_n=0, async):
  - all 2**RW registers = 0
  - e_valid = 0
  - alu_cmd_o = 0 (NOP), alu_ina_o = alu_inb_o = 0
  - carry flag = 0, parity flag = 0
  - commit_o = 0
- dec_ready_o = !stall_i (with ALU_FWD_EN; see Optional Feature otherwise).
- accept = dec_valid_i && dec_ready_o.
- commit_o = e_valid && !stall_i. Combinational; ALU settles within the same cycle.
- On a commit edge:
  - if e_we: R[e_rd] <= alu_rslt_i
  - carry <= alu_sc_i
  - parity <= alu_pari_i
  - flags update even when e_we = 0
- Issue register update at posedge:
  - stall_i=1: hold all issue-register contents and e_valid.
  - else if accept: load cmd/rd/we, operands, e_valid <= 1.
  - else: e_valid <= 0 and alu_cmd_o <= 0, so the ALU sees NOP during bubbles. Operands hold.
- Operand select at accept:
  - A = imm_sel ? dec_imm_i : fwdA
  - B = fwdB
  - fwdX = (commit_o && e_we && e_rd == dec_rX_i) ? alu_rslt_i : R[dec_rX_i]
- Bypass priority is over the register file. A write and a read of the same index on the same edge returns the new value.
- ra == rb == e_rd forwards to both operands.
- Back-to-back accepts sustain 1 instruction/cycle. Latency from accept to commit is 1 cycle absent stall.
- stall_i mid-operation: no state changes except debug read. On release, the held instruction commits using the current ALU output.
- Register index wraps naturally at 2**RW; there is no out-of-range case.
- Reset asserted mid-instruction discards the in-flight instruction; no partial writeback.

Optional Feature:
- Macro: ALU_FWD_EN.
- Defined: bypass path as above.
- Undefined: no bypass.
  - RAW hazard = e_valid && e_we && (e_rd == dec_ra_i && !dec_imm_sel_i || e_rd == dec_rb_i).
  - dec_ready_o = !stall_i && !hazard.
  - The dependent instruction is accepted the cycle after the producer commits, reading the written value from the register file (1-cycle bubble).

Test Plan:
- Reset mid-stream: after 3 accepts, pulse rst_n low -> all outputs 0, dbg_data_o=0 for every index, commit_o=0 the next cycle.
- Back-to-back RAW: R1=5 via imm+nop_a, then add R2=R1+R1 the next cycle -> with ALU_FWD_EN, no bubble and R2=10. Without ALU_FWD_EN, dec_ready_o low for exactly 1 cycle and R2=10.
- Stall hold: issue sub (R3=9, R4=4) into R5, hold stall_i=1 for 4 cycles -> commit_o=0, alu_ina_o/alu_inb_o stay 9/4, R5 unchanged. On release R5=5 and commit_o pulses once.
- Bubble: dec_valid_i=0 for 2 cycles after an xor -> alu_cmd_o=0 during the bubble, no register writes, flags unchanged.
- Flags: pari command on B=8'b0000_0111 with we=0 -> no register write, flag_pari_o=1 after commit.
- Write/read collision: commit to R7=8'hA5 while accepting an instruction reading R7 on B -> alu_inb_o=8'hA5.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-issue stage directly upstream of an 8-bit
// combinational ALU. Accepts decoded instructions over valid/ready, reads the
// register file, holds operands in an issue register driving the ALU and
// writes the ALU result back on commit. Owns the carry and parity flags.
//
// Optional feature macro: ALU_FWD_EN
//   defined   - the committing result is bypassed into operand select, so a
//               dependent instruction issues back-to-back with no bubble.
//   undefined - no bypass; a RAW hazard against the in-flight instruction
//               holds dec_ready_o low until the producer has written back.
module alu_issue_stage #(
  parameter int A  = 3,
  parameter int DW = 8,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_i,
  input  logic          dec_valid_i,
  output logic          dec_ready_o,
  input  logic [A:0]    dec_cmd_i,
  input  logic [RW-1:0] dec_ra_i,
  input  logic [RW-1:0] dec_rb_i,
  input  logic [RW-1:0] dec_rd_i,
  input  logic          dec_we_i,
  input  logic          dec_imm_sel_i,
  input  logic [DW-1:0] dec_imm_i,
  output logic [A:0]    alu_cmd_o,
  output logic [DW-1:0] alu_ina_o,
  output logic [DW-1:0] alu_inb_o,
  output logic          alu_sc_o,
  input  logic [DW-1:0] alu_rslt_i,
  input  logic          alu_sc_i,
  input  logic          alu_pari_i,
  output logic          commit_o,
  output logic          flag_pari_o,
  input  logic [RW-1:0] dbg_addr_i,
  output logic [DW-1:0] dbg_data_o
);

  localparam int NREG = 2 ** RW;

  // Architectural state
  logic [DW-1:0] regs_r [NREG];
  logic          carry_r;
  logic          pari_r;

  // Issue register
  logic          e_valid_r;
  logic          e_we_r;
  logic [RW-1:0] e_rd_r;
  logic [A:0]    cmd_r;
  logic [DW-1:0] ina_r;
  logic [DW-1:0] inb_r;

  // Handshake and bypass controls
  logic          commit_s;
  logic          wr_en_s;
  logic          hazard_s;
  logic          ready_s;
  logic          accept_s;
  logic          hit_a_s;
  logic          hit_b_s;

  // Operand select
  logic [DW-1:0] fwd_a_s;
  logic [DW-1:0] fwd_b_s;
  logic [DW-1:0] opa_s;

  // Commit, hazard/bypass detection and the decoder handshake.
  always_comb begin
    commit_s = e_valid_r && !stall_i;
    wr_en_s  = commit_s && e_we_r;
`ifdef ALU_FWD_EN
    // The committing result is bypassed, so no dependency ever blocks issue.
    hazard_s = 1'b0;
    hit_a_s  = wr_en_s && (e_rd_r == dec_ra_i);
    hit_b_s  = wr_en_s && (e_rd_r == dec_rb_i);
`else
    // Without a bypass, any register read that matches the pending write
    // must wait until that write has landed in the register file.
    hazard_s = e_valid_r && e_we_r &&
               (((e_rd_r == dec_ra_i) && !dec_imm_sel_i) || (e_rd_r == dec_rb_i));
    hit_a_s  = 1'b0;
    hit_b_s  = 1'b0;
`endif
    ready_s  = !stall_i && !hazard_s;
    accept_s = dec_valid_i && ready_s;
  end

  // Operand selection: bypass beats the register file, immediate beats both on A.
  always_comb begin
    if (hit_a_s) begin
      fwd_a_s = alu_rslt_i;
    end else begin
      fwd_a_s = regs_r[dec_ra_i];
    end
    if (hit_b_s) begin
      fwd_b_s = alu_rslt_i;
    end else begin
      fwd_b_s = regs_r[dec_rb_i];
    end
    if (dec_imm_sel_i) begin
      opa_s = dec_imm_i;
    end else begin
      opa_s = fwd_a_s;
    end
  end

  // Register file: cleared on reset, written with the ALU result on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DW{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[e_rd_r] <= alu_rslt_i;
    end
  end

  // Flags follow every commit, whether or not the result is written back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_r <= 1'b0;
      pari_r  <= 1'b0;
    end else if (commit_s) begin
      carry_r <= alu_sc_i;
      pari_r  <= alu_pari_i;
    end
  end

  // Issue register: load on accept, NOP the command during bubbles, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_r <= 1'b0;
      e_we_r    <= 1'b0;
      e_rd_r    <= {RW{1'b0}};
      cmd_r     <= {(A+1){1'b0}};
      ina_r     <= {DW{1'b0}};
      inb_r     <= {DW{1'b0}};
    end else if (!stall_i) begin
      if (accept_s) begin
        e_valid_r <= 1'b1;
        e_we_r    <= dec_we_i;
        e_rd_r    <= dec_rd_i;
        cmd_r     <= dec_cmd_i;
        ina_r     <= opa_s;
        inb_r     <= fwd_b_s;
      end else begin
        // Operands deliberately hold; only the command is forced to NOP.
        e_valid_r <= 1'b0;
        cmd_r     <= {(A+1){1'b0}};
      end
    end
  end

  assign dec_ready_o = ready_s;
  assign commit_o    = commit_s;
  assign alu_cmd_o   = cmd_r;
  assign alu_ina_o   = ina_r;
  assign alu_inb_o   = inb_r;
  assign alu_sc_o    = carry_r;
  assign flag_pari_o = pari_r;
  assign dbg_data_o  = regs_r[dbg_addr_i];

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: self-checking bench for alu_issue_stage. A behavioural
// ALU drives the result inputs; a program-order reference model (committed
// registers plus one pending instruction) predicts handshake, ALU operands,
// flags and register contents. Honours ALU_FWD_EN like the design.
module tb_alu_issue_stage;

  localparam int NREG = 8;
  localparam logic [3:0] C_NOP   = 4'd0;
  localparam logic [3:0] C_PASSA = 4'd1;
  localparam logic [3:0] C_ADD   = 4'd2;
  localparam logic [3:0] C_SUB   = 4'd3;
  localparam logic [3:0] C_XOR   = 4'd4;
  localparam logic [3:0] C_AND   = 4'd5;
  localparam logic [3:0] C_OR    = 4'd6;
  localparam logic [3:0] C_SHL   = 4'd7;
  localparam logic [3:0] C_SHR   = 4'd8;
  localparam logic [3:0] C_PARI  = 4'd9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic       dec_valid = 1'b0;
  logic       dec_ready;
  logic [3:0] dec_cmd = 4'd0;
  logic [2:0] dec_ra = 3'd0;
  logic [2:0] dec_rb = 3'd0;
  logic [2:0] dec_rd = 3'd0;
  logic       dec_we = 1'b0;
  logic       dec_imm_sel = 1'b0;
  logic [7:0] dec_imm = 8'd0;
  logic [3:0] alu_cmd;
  logic [7:0] alu_ina;
  logic [7:0] alu_inb;
  logic       alu_sc_out;
  logic [7:0] alu_rslt;
  logic       alu_sc;
  logic       alu_pari;
  logic       commit;
  logic       flag_pari;
  logic [2:0] dbg_addr = 3'd0;
  logic [7:0] dbg_data;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_regs [NREG];
  logic       m_carry, m_pari;
  logic       p_valid, p_we, p_sc, p_pari;
  logic [2:0] p_rd;
  logic [7:0] p_res;
  logic [3:0] x_cmd;
  logic [7:0] x_a, x_b;

  alu_issue_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .dec_valid_i   (dec_valid),
    .dec_ready_o   (dec_ready),
    .dec_cmd_i     (dec_cmd),
    .dec_ra_i      (dec_ra),
    .dec_rb_i      (dec_rb),
    .dec_rd_i      (dec_rd),
    .dec_we_i      (dec_we),
    .dec_imm_sel_i (dec_imm_sel),
    .dec_imm_i     (dec_imm),
    .alu_cmd_o     (alu_cmd),
    .alu_ina_o     (alu_ina),
    .alu_inb_o     (alu_inb),
    .alu_sc_o      (alu_sc_out),
    .alu_rslt_i    (alu_rslt),
    .alu_sc_i      (alu_sc),
    .alu_pari_i    (alu_pari),
    .commit_o      (commit),
    .flag_pari_o   (flag_pari),
    .dbg_addr_i    (dbg_addr),
    .dbg_data_o    (dbg_data)
  );

  always #20 clk = ~clk;

  // Behavioural ALU: returns {parity, shift-carry, result}.
  function automatic logic [9:0] alu_fn(input logic [3:0] c, input logic [7:0] a,
                                        input logic [7:0] b, input logic ci);
    logic [8:0] w;
    logic [7:0] r;
    logic       so;
    r  = 8'h00;
    so = 1'b0;
    w  = 9'd0;
    case (c)
      C_NOP:   r = 8'h00;
      C_PASSA: r = a;
      C_ADD:   begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; so = w[8]; end
      C_SUB:   begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; so = w[8]; end
      C_XOR:   r = a ^ b;
      C_AND:   r = a & b;
      C_OR:    r = a | b;
      C_SHL:   begin r = {a[6:0], ci}; so = a[7]; end
      C_SHR:   begin r = {ci, a[7:1]}; so = a[0]; end
      C_PARI:  r = 8'h00;
      default: begin w = {1'b0, a} + {1'b0, b} + {8'd0, ci}; r = w[7:0]; so = w[8]; end
    endcase
    return {((c == C_PARI) ? ^b : ^r), so, r};
  endfunction

  always_comb {alu_pari, alu_sc, alu_rslt} = alu_fn(alu_cmd, alu_ina, alu_inb, alu_sc_out);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
    m_carry = 1'b0; m_pari = 1'b0;
    p_valid = 1'b0; p_we = 1'b0; p_rd = 3'd0; p_res = 8'h00; p_sc = 1'b0; p_pari = 1'b0;
    x_cmd = 4'd0; x_a = 8'h00; x_b = 8'h00;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = 3'(i);
      #1;
      check(tag, dbg_data, m_regs[i]);
    end
  endtask

  // One clock: drive at negedge, check handshake, then check registered outputs after the edge.
  task automatic cycle(input logic v, input logic [3:0] c, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [2:0] rd, input logic we,
                       input logic isel, input logic [7:0] imm, input logic st,
                       output logic acc);
    logic       exp_commit, hazard, exp_ready;
    logic [7:0] a, b;
    logic [9:0] r;
    @(negedge clk);
    dec_valid = v; dec_cmd = c; dec_ra = ra; dec_rb = rb; dec_rd = rd;
    dec_we = we; dec_imm_sel = isel; dec_imm = imm; stall = st;
    #1;
    exp_commit = p_valid && !st;
`ifdef ALU_FWD_EN
    hazard = 1'b0;
`else
    hazard = p_valid && p_we && (((p_rd == ra) && !isel) || (p_rd == rb));
`endif
    exp_ready = !st && !hazard;
    check("dec_ready", dec_ready, exp_ready);
    check("commit", commit, exp_commit);
    acc = v && exp_ready;
    @(posedge clk);
    if (exp_commit) begin
      if (p_we) m_regs[p_rd] = p_res;
      m_carry = p_sc;
      m_pari  = p_pari;
      p_valid = 1'b0;
    end
    if (acc) begin
      a = isel ? imm : m_regs[ra];
      b = m_regs[rb];
      r = alu_fn(c, a, b, m_carry);
      p_valid = 1'b1; p_we = we; p_rd = rd;
      p_res = r[7:0]; p_sc = r[8]; p_pari = r[9];
      x_cmd = c; x_a = a; x_b = b;
    end else if (!st) begin
      x_cmd = 4'd0;
    end
    #1;
    check("alu_cmd", alu_cmd, x_cmd);
    check("alu_ina", alu_ina, x_a);
    check("alu_inb", alu_inb, x_b);
    check("carry_flag", alu_sc_out, m_carry);
    check("parity_flag", flag_pari, m_pari);
  endtask

  // Present one instruction until accepted; reports cycles it was refused.
  task automatic issue(input logic [3:0] c, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [2:0] rd, input logic we, input logic isel,
                       input logic [7:0] imm, output int waits);
    logic acc;
    acc = 1'b0;
    waits = 0;
    while (!acc && waits < 8) begin
      cycle(1'b1, c, ra, rb, rd, we, isel, imm, 1'b0, acc);
      if (!acc) waits++;
    end
    check("accept_bound", acc, 1'b1);
  endtask

  task automatic idle(input int n, input logic st);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, C_NOP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, st, acc);
  endtask

  task automatic reset_checks();
    check("rst_alu_cmd", alu_cmd, 4'd0);
    check("rst_alu_ina", alu_ina, 8'h00);
    check("rst_alu_inb", alu_inb, 8'h00);
    check("rst_commit", commit, 1'b0);
    check("rst_carry", alu_sc_out, 1'b0);
    check("rst_parity", flag_pari, 1'b0);
    check_regs("rst_reg");
  endtask

  initial begin
    #(40 * 50000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   waits;
    logic acc;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back RAW: R1 = 5, then R2 = R1 + R1.
    issue(C_PASSA, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 8'd5, waits);
    issue(C_ADD, 3'd1, 3'd1, 3'd2, 1'b1, 1'b0, 8'h00, waits);
`ifdef ALU_FWD_EN
    check("raw_bubbles", waits, 0);
`else
    check("raw_bubbles", waits, 1);
`endif
    idle(2, 1'b0);
    dbg_addr = 3'd2; #1;
    check("raw_r2", dbg_data, 8'd10);

    // Stall hold: R5 = R3 - R4 with 4 stalled cycles.
    issue(C_PASSA, 3'd0, 3'd0, 3'd3, 1'b1, 1'b1, 8'd9, waits);
    issue(C_PASSA, 3'd0, 3'd0, 3'd4, 1'b1, 1'b1, 8'd4, waits);
    issue(C_SUB, 3'd3, 3'd4, 3'd5, 1'b1, 1'b0, 8'h00, waits);
    idle(4, 1'b1);
    check("stall_ina", alu_ina, 8'd9);
    check("stall_inb", alu_inb, 8'd4);
    dbg_addr = 3'd5; #1;
    check("stall_r5_held", dbg_data, 8'd0);
    idle(2, 1'b0);
    dbg_addr = 3'd5; #1;
    check("stall_r5_done", dbg_data, 8'd5);

    // Bubble after an xor: R6 = 9 ^ 4, then NOP command with no writes.
    issue(C_XOR, 3'd3, 3'd4, 3'd6, 1'b1, 1'b0, 8'h00, waits);
    idle(1, 1'b0);
    check("bubble_cmd", alu_cmd, 4'd0);
    idle(1, 1'b0);
    check_regs("bubble_reg");

    // Parity flag from a no-writeback command on B = 8'b0000_0111.
    issue(C_PASSA, 3'd0, 3'd0, 3'd6, 1'b1, 1'b1, 8'b0000_0111, waits);
    issue(C_PARI, 3'd0, 3'd6, 3'd0, 1'b0, 1'b0, 8'h00, waits);
    idle(1, 1'b0);
    check("pari_flag", flag_pari, 1'b1);
    dbg_addr = 3'd0; #1;
    check("pari_no_write", dbg_data, 8'h00);

    // Write/read collision on R7.
    issue(C_PASSA, 3'd0, 3'd0, 3'd7, 1'b1, 1'b1, 8'hA5, waits);
    issue(C_XOR, 3'd0, 3'd7, 3'd1, 1'b1, 1'b0, 8'h00, waits);
    check("collision_inb", alu_inb, 8'hA5);
    idle(1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 9) < 8), 4'($urandom_range(0, 10)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 9) == 0), acc);
      if ((n % 50) == 49) check_regs("rand_reg");
    end
    idle(2, 1'b0);
    check_regs("rand_final");

    // Reset mid-stream after three accepts.
    issue(C_PASSA, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 8'h11, waits);
    issue(C_PASSA, 3'd0, 3'd0, 3'd2, 1'b1, 1'b1, 8'h22, waits);
    issue(C_PASSA, 3'd0, 3'd0, 3'd3, 1'b1, 1'b1, 8'h33, waits);
    dec_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1'b0);
    check_regs("post_rst_reg");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
